// File: rtl/arm_instr_encoder_pkg.sv
// Shared definitions for the ARMv4 instruction encoder: family numbers,
// field widths and the request payload carried from the input port to the packer.
package arm_instr_encoder_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned BODY_W  = 28;
  localparam int unsigned FNUM_W  = 4;
  localparam int unsigned REG_W   = 4;
  localparam int unsigned PUBWL_W = 5;
  localparam int unsigned SHIMM_W = 5;
  localparam int unsigned IMM_W   = 24;

  // Family numbers shared with the decoder
  localparam logic [FNUM_W-1:0] F_DPI  = 4'd0;   // data processing, immediate
  localparam logic [FNUM_W-1:0] F_DPR  = 4'd1;   // data processing, shift by immediate
  localparam logic [FNUM_W-1:0] F_DPRS = 4'd2;   // data processing, shift by register
  localparam logic [FNUM_W-1:0] F_MUL  = 4'd3;   // MUL/MLA
  localparam logic [FNUM_W-1:0] F_MULL = 4'd4;   // UMULL/SMULL/UMLAL/SMLAL
  localparam logic [FNUM_W-1:0] F_MRS  = 4'd5;   // MRS
  localparam logic [FNUM_W-1:0] F_MSRI = 4'd6;   // MSR immediate
  localparam logic [FNUM_W-1:0] F_MSRR = 4'd7;   // MSR register
  localparam logic [FNUM_W-1:0] F_LSI  = 4'd8;   // LDR/STR immediate offset
  localparam logic [FNUM_W-1:0] F_LSR  = 4'd9;   // LDR/STR register offset
  localparam logic [FNUM_W-1:0] F_LSHI = 4'd10;  // halfword/signed, immediate offset
  localparam logic [FNUM_W-1:0] F_LSHR = 4'd11;  // halfword/signed, register offset
  localparam logic [FNUM_W-1:0] F_SWP  = 4'd12;  // SWP/SWPB
  localparam logic [FNUM_W-1:0] F_LDM  = 4'd13;  // LDM/STM
  localparam logic [FNUM_W-1:0] F_BR   = 4'd14;  // B/BL
  localparam logic [FNUM_W-1:0] F_UND  = 4'd15;  // architecturally undefined

  localparam logic [BODY_W-1:0] UND_BODY = 28'h600_0010;

  typedef struct packed {
    logic [FNUM_W-1:0]  fnum;
    logic [3:0]         cond;
    logic [3:0]         op;
    logic               s;
    logic [PUBWL_W-1:0] pubwl;
    logic [REG_W-1:0]   rn;
    logic [REG_W-1:0]   rd;
    logic [REG_W-1:0]   rs;
    logic [REG_W-1:0]   rm;
    logic [1:0]         sh;
    logic [SHIMM_W-1:0] shimm;
    logic [IMM_W-1:0]   imm;
  } enc_req_t;

endpackage

// File: rtl/arm_instr_pack.sv
// Combinational field packer: builds the instruction word for a request and
// flags field combinations whose encoding would alias a different family.
module arm_instr_pack
  import arm_instr_encoder_pkg::*;
(
  input  enc_req_t           req,
  output logic [WORD_W-1:0]  ir_c,
  output logic               err_c
);

  logic [BODY_W-1:0] body;
  logic              dp_family;
  logic              hw_family;

  always_comb begin
    body = UND_BODY;
    unique case (req.fnum)
      F_DPI:  body = {3'b001, req.op, req.s, req.rn, req.rd, req.imm[11:0]};
      F_DPR:  body = {3'b000, req.op, req.s, req.rn, req.rd, req.shimm, req.sh, 1'b0, req.rm};
      F_DPRS: body = {3'b000, req.op, req.s, req.rn, req.rd, req.rs, 1'b0, req.sh, 1'b1, req.rm};
      F_MUL:  body = {6'b000000, req.op[0], req.s, req.rd, req.rn, req.rs, 4'b1001, req.rm};
      F_MULL: body = {5'b00001, req.op[1], req.op[0], req.s, req.rd, req.rn, req.rs,
                      4'b1001, req.rm};
      F_MRS:  body = {5'b00010, req.op[0], 2'b00, 4'hF, req.rd, 12'h000};
      F_MSRI: body = {5'b00110, req.op[0], 2'b10, req.rn, 4'hF, req.imm[11:0]};
      F_MSRR: body = {5'b00010, req.op[0], 2'b10, req.rn, 4'hF, 8'h00, req.rm};
      F_LSI:  body = {3'b010, req.pubwl, req.rn, req.rd, req.imm[11:0]};
      F_LSR:  body = {3'b011, req.pubwl, req.rn, req.rd, req.shimm, req.sh, 1'b0, req.rm};
      // Halfword forms reuse the B position as the immediate/register selector
      F_LSHI: body = {3'b000, req.pubwl[4:3], 1'b1, req.pubwl[1:0], req.rn, req.rd,
                      req.imm[7:4], 1'b1, req.sh, 1'b1, req.imm[3:0]};
      F_LSHR: body = {3'b000, req.pubwl[4:3], 1'b0, req.pubwl[1:0], req.rn, req.rd,
                      4'h0, 1'b1, req.sh, 1'b1, req.rm};
      F_SWP:  body = {5'b00010, req.op[0], 2'b00, req.rn, req.rd, 4'h0, 4'b1001, req.rm};
      F_LDM:  body = {3'b100, req.pubwl[4:3], req.s, req.pubwl[1:0], req.rn, req.imm[15:0]};
      F_BR:   body = {3'b101, req.pubwl[0], req.imm};
      default: body = UND_BODY;
    endcase
  end

  assign dp_family = (req.fnum == F_DPI) || (req.fnum == F_DPR) || (req.fnum == F_DPRS);
  assign hw_family = (req.fnum == F_LSHI) || (req.fnum == F_LSHR);

  // TST/TEQ/CMP/CMN without S collide with MRS/MSR/SWP; SH=00 collides with SWP/MUL
  assign err_c = (dp_family && (req.op[3:2] == 2'b10) && !req.s)
              || (hw_family && (req.sh == 2'b00))
              || ((req.fnum == F_LDM) && (req.imm[15:0] == 16'h0000));

  assign ir_c = {req.cond, body};

endmodule

// File: rtl/arm_instr_encoder.sv
// Streaming instruction encoder: packs each accepted request and buffers the
// resulting words in a two-entry FIFO, counting words and erroneous words popped.
module arm_instr_encoder
  import arm_instr_encoder_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [FNUM_W-1:0]   in_fnum,
  input  logic [3:0]          in_cond,
  input  logic [3:0]          in_op,
  input  logic                in_s,
  input  logic [PUBWL_W-1:0]  in_pubwl,
  input  logic [REG_W-1:0]    in_rn,
  input  logic [REG_W-1:0]    in_rd,
  input  logic [REG_W-1:0]    in_rs,
  input  logic [REG_W-1:0]    in_rm,
  input  logic [1:0]          in_sh,
  input  logic [SHIMM_W-1:0]  in_shimm,
  input  logic [IMM_W-1:0]    in_imm,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WORD_W-1:0]   out_ir,
  output logic                out_err,
  output logic [15:0]         instr_count,
  output logic [7:0]          err_count
);

  localparam int unsigned CNT_W = 2;

  enc_req_t           req;
  logic [WORD_W-1:0]  ir_c;
  logic               err_c;
  logic [WORD_W-1:0]  fifo_ir  [DEPTH];
  logic               fifo_err [DEPTH];
  logic               wr_ptr;
  logic               rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               push;
  logic               pop;

  always_comb begin
    req       = '0;
    req.fnum  = in_fnum;
    req.cond  = in_cond;
    req.op    = in_op;
    req.s     = in_s;
    req.pubwl = in_pubwl;
    req.rn    = in_rn;
    req.rd    = in_rd;
    req.rs    = in_rs;
    req.rm    = in_rm;
    req.sh    = in_sh;
    req.shimm = in_shimm;
    req.imm   = in_imm;
  end

  arm_instr_pack u_pack (
    .req   (req),
    .ir_c  (ir_c),
    .err_c (err_c)
  );

  // A full FIFO can still accept when the head is leaving this cycle
  assign out_valid = (count != '0);
  assign in_ready  = (count < CNT_W'(DEPTH)) || out_ready;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_ir    = fifo_ir[rd_ptr];
  assign out_err   = fifo_err[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        fifo_ir[i]  <= '0;
        fifo_err[i] <= 1'b0;
      end
    end else begin
      if (push) begin
        fifo_ir[wr_ptr]  <= ir_c;
        fifo_err[wr_ptr] <= err_c;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // Pop statistics; error count saturates rather than wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_count <= '0;
      err_count   <= '0;
    end else if (pop) begin
      instr_count <= instr_count + 16'd1;
      if (out_err && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_arm_instr_encoder.sv
// Bench for arm_instr_encoder: cycle-level scoreboard with an arithmetic
// reference encoder and an independent ARMv4 family classifier.
module tb_arm_instr_encoder;

  typedef struct {
    logic [3:0]  fnum;
    logic [3:0]  cond;
    logic [3:0]  op;
    logic        s;
    logic [4:0]  pubwl;
    logic [3:0]  rn, rd, rs, rm;
    logic [1:0]  sh;
    logic [4:0]  shimm;
    logic [23:0] imm;
    bit          rt;
  } req_t;

  typedef struct {
    logic [31:0] w;
    logic        e;
    logic [3:0]  f;
    bit          rt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [3:0]  in_fnum, in_cond, in_op;
  logic        in_s;
  logic [4:0]  in_pubwl;
  logic [3:0]  in_rn, in_rd, in_rs, in_rm;
  logic [1:0]  in_sh;
  logic [4:0]  in_shimm;
  logic [23:0] in_imm;
  logic        out_valid, out_ready;
  logic [31:0] out_ir;
  logic        out_err;
  logic [15:0] instr_count;
  logic [7:0]  err_count;

  int nerr = 0;
  int nchk = 0;
  int cyc  = 0;
  int rmode = 1;
  req_t pend[$];
  exp_t sb[$];
  logic [31:0] got[$];
  int gcyc[$];
  logic [15:0] m_icnt = '0;
  logic [7:0]  m_ecnt = '0;

  arm_instr_encoder #(.DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fnum(in_fnum), .in_cond(in_cond), .in_op(in_op), .in_s(in_s),
    .in_pubwl(in_pubwl), .in_rn(in_rn), .in_rd(in_rd), .in_rs(in_rs), .in_rm(in_rm),
    .in_sh(in_sh), .in_shimm(in_shimm), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ir(out_ir), .out_err(out_err),
    .instr_count(instr_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nchk++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference encoder: each field shifted to its architectural bit position
  function automatic logic [31:0] ref_enc(input req_t r);
    logic [31:0] w;
    w = 32'(r.cond) << 28;
    case (r.fnum)
      4'd0:  w |= 32'h0200_0000 | 32'(r.op) << 21 | 32'(r.s) << 20 | 32'(r.rn) << 16
                | 32'(r.rd) << 12 | 32'(r.imm[11:0]);
      4'd1:  w |= 32'(r.op) << 21 | 32'(r.s) << 20 | 32'(r.rn) << 16 | 32'(r.rd) << 12
                | 32'(r.shimm) << 7 | 32'(r.sh) << 5 | 32'(r.rm);
      4'd2:  w |= 32'(r.op) << 21 | 32'(r.s) << 20 | 32'(r.rn) << 16 | 32'(r.rd) << 12
                | 32'(r.rs) << 8 | 32'(r.sh) << 5 | 32'h10 | 32'(r.rm);
      4'd3:  w |= 32'(r.op[0]) << 21 | 32'(r.s) << 20 | 32'(r.rd) << 16 | 32'(r.rn) << 12
                | 32'(r.rs) << 8 | 32'h90 | 32'(r.rm);
      4'd4:  w |= 32'h0080_0000 | 32'(r.op[1:0]) << 21 | 32'(r.s) << 20 | 32'(r.rd) << 16
                | 32'(r.rn) << 12 | 32'(r.rs) << 8 | 32'h90 | 32'(r.rm);
      4'd5:  w |= 32'h010F_0000 | 32'(r.op[0]) << 22 | 32'(r.rd) << 12;
      4'd6:  w |= 32'h0320_F000 | 32'(r.op[0]) << 22 | 32'(r.rn) << 16 | 32'(r.imm[11:0]);
      4'd7:  w |= 32'h0120_F000 | 32'(r.op[0]) << 22 | 32'(r.rn) << 16 | 32'(r.rm);
      4'd8:  w |= 32'h0400_0000 | 32'(r.pubwl) << 20 | 32'(r.rn) << 16 | 32'(r.rd) << 12
                | 32'(r.imm[11:0]);
      4'd9:  w |= 32'h0600_0000 | 32'(r.pubwl) << 20 | 32'(r.rn) << 16 | 32'(r.rd) << 12
                | 32'(r.shimm) << 7 | 32'(r.sh) << 5 | 32'(r.rm);
      4'd10: w |= 32'(r.pubwl | 5'b00100) << 20 | 32'(r.rn) << 16 | 32'(r.rd) << 12
                | 32'(r.imm[7:4]) << 8 | 32'h90 | 32'(r.sh) << 5 | 32'(r.imm[3:0]);
      4'd11: w |= 32'(r.pubwl & 5'b11011) << 20 | 32'(r.rn) << 16 | 32'(r.rd) << 12
                | 32'h90 | 32'(r.sh) << 5 | 32'(r.rm);
      4'd12: w |= 32'h0100_0090 | 32'(r.op[0]) << 22 | 32'(r.rn) << 16 | 32'(r.rd) << 12
                | 32'(r.rm);
      4'd13: w |= 32'h0800_0000 | 32'(r.pubwl & 5'b11011) << 20 | 32'(r.s) << 22
                | 32'(r.rn) << 16 | 32'(r.imm[15:0]);
      4'd14: w |= 32'h0A00_0000 | 32'(r.pubwl[0]) << 24 | 32'(r.imm);
      default: w |= 32'h0600_0010;
    endcase
    return w;
  endfunction

  function automatic logic ref_err(input req_t r);
    int f, op;
    f = int'(r.fnum);
    op = int'(r.op);
    return (f <= 2 && op >= 8 && op <= 11 && r.s == 1'b0)
        || ((f == 10 || f == 11) && r.sh == 2'b00)
        || (f == 13 && r.imm[15:0] == 16'h0);
  endfunction

  // Family classifier following the ARMv4 decode tables
  function automatic logic [3:0] fam_of(input logic [31:0] w);
    case (w[27:25])
      3'b000: begin
        if (w[7:4] == 4'b1001) begin
          if (w[27:22] == 6'b000000) return 4'd3;
          if (w[27:23] == 5'b00001) return 4'd4;
          if (w[27:23] == 5'b00010 && w[21:20] == 2'b00) return 4'd12;
          return 4'd15;
        end
        if (w[7] && w[4]) return w[22] ? 4'd10 : 4'd11;
        if (w[24:23] == 2'b10 && !w[20]) return w[21] ? 4'd7 : 4'd5;
        return w[4] ? 4'd2 : 4'd1;
      end
      3'b001: begin
        if (w[24:23] == 2'b10 && !w[20]) return w[21] ? 4'd6 : 4'd15;
        return 4'd0;
      end
      3'b010: return 4'd8;
      3'b011: return w[4] ? 4'd15 : 4'd9;
      3'b100: return 4'd13;
      3'b101: return 4'd14;
      default: return 4'd15;
    endcase
  endfunction

  function automatic req_t mk(input int f, input int cond, input int op, input int s,
                              input int pubwl, input int rn, input int rd,
                              input int imm);
    req_t r;
    r.fnum = 4'(f);  r.cond = 4'(cond); r.op = 4'(op); r.s = 1'(s);
    r.pubwl = 5'(pubwl); r.rn = 4'(rn); r.rd = 4'(rd); r.rs = 4'h0; r.rm = 4'h0;
    r.sh = 2'b00; r.shimm = 5'h0; r.imm = 24'(imm); r.rt = 1'b0;
    return r;
  endfunction

  function automatic req_t rnd(input bit legal, input int f);
    req_t r;
    r.fnum = 4'(f);           r.cond = 4'($urandom); r.op = 4'($urandom);
    r.s = 1'($urandom);       r.pubwl = 5'($urandom);
    r.rn = 4'($urandom);      r.rd = 4'($urandom);   r.rs = 4'($urandom);
    r.rm = 4'($urandom);      r.sh = 2'($urandom);   r.shimm = 5'($urandom);
    r.imm = 24'($urandom);    r.rt = legal;
    if (legal) begin
      if (f <= 2 && r.op[3:2] == 2'b10) r.s = 1'b1;
      if ((f == 10 || f == 11) && r.sh == 2'b00) r.sh = 2'($urandom_range(1, 3));
      if (f == 13 && r.imm[15:0] == 16'h0) r.imm[0] = 1'b1;
    end
    return r;
  endfunction

  task automatic drive();
    req_t r;
    if (pend.size() != 0) begin
      r = pend[0];
      in_valid = 1'b1; in_fnum = r.fnum; in_cond = r.cond; in_op = r.op; in_s = r.s;
      in_pubwl = r.pubwl; in_rn = r.rn; in_rd = r.rd; in_rs = r.rs; in_rm = r.rm;
      in_sh = r.sh; in_shimm = r.shimm; in_imm = r.imm;
    end else begin
      in_valid = 1'b0;
    end
    out_ready = (rmode == 0) ? 1'b0 : (rmode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
  endtask

  // One clock: check DUT against the model at mid-cycle, then advance the model
  task automatic cycle();
    logic exp_rdy, pop, acc;
    exp_t e;
    drive();
    #1;
    exp_rdy = (sb.size() < 2) || out_ready;
    pop = (sb.size() != 0) && out_ready;
    acc = in_valid && exp_rdy;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
    chk("instr_count", 32'(instr_count), 32'(m_icnt));
    chk("err_count", 32'(err_count), 32'(m_ecnt));
    if (pop) begin
      chk("out_ir", out_ir, sb[0].w);
      chk("out_err", 32'(out_err), 32'(sb[0].e));
      if (sb[0].rt) chk("rt_family", 32'(fam_of(out_ir)), 32'(sb[0].f));
      got.push_back(out_ir);
      gcyc.push_back(cyc);
    end
    @(posedge clk);
    if (pop) begin
      if (sb[0].e && m_ecnt != 8'hFF) m_ecnt++;
      m_icnt++;
      void'(sb.pop_front());
    end
    if (acc) begin
      e.w = ref_enc(pend[0]); e.e = ref_err(pend[0]);
      e.f = pend[0].fnum;     e.rt = pend[0].rt;
      sb.push_back(e);
      void'(pend.pop_front());
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain(input int mode, input int budget);
    int n = 0;
    rmode = mode;
    while ((pend.size() != 0 || sb.size() != 0) && n < budget) begin
      cycle();
      n++;
    end
    chk("drain_leftover", 32'(pend.size() + sb.size()), 32'd0);
    cycle();
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_out_ir"}, out_ir, 32'd0);
    chk({tag, "_out_err"}, 32'(out_err), 32'd0);
    chk({tag, "_instr_count"}, 32'(instr_count), 32'd0);
    chk({tag, "_err_count"}, 32'(err_count), 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_fnum = '0; in_cond = '0; in_op = '0; in_s = 1'b0; in_pubwl = '0;
    in_rn = '0; in_rd = '0; in_rs = '0; in_rm = '0; in_sh = '0; in_shimm = '0; in_imm = '0;
    #1;
    check_reset_state("reset");
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Single DP immediate: ADD r2, r1, #0xFF
    got.delete(); gcyc.delete();
    pend.push_back(mk(0, 14, 4, 0, 0, 1, 2, 12'h0FF));
    drain(1, 10);
    chk("f0_word", got[0], 32'hE28120FF);
    chk("f0_instr_count", 32'(instr_count), 32'd1);

    // BL then LDR back-to-back, popped on consecutive cycles
    got.delete(); gcyc.delete();
    pend.push_back(mk(14, 14, 0, 0, 5'b00001, 0, 0, 24'h00000A));
    pend.push_back(mk(8, 14, 0, 0, 5'b11001, 13, 0, 4));
    drain(1, 10);
    chk("bl_word", got[0], 32'hEB00000A);
    chk("ldr_word", got[1], 32'hE59D0004);
    chk("b2b_spacing", 32'(gcyc[1] - gcyc[0]), 32'd1);

    // Backpressure: three requests, only two fit while the consumer stalls
    got.delete(); gcyc.delete();
    for (int i = 0; i < 3; i++) pend.push_back(rnd(1'b1, i * 5));
    rmode = 0;
    for (int i = 0; i < 4; i++) cycle();
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    drain(1, 10);

    // CMP without S aliases the misc space: flagged, counted, saturating
    for (int i = 0; i < 300; i++) pend.push_back(mk(1, 14, 10, 0, 0, 3, 0, 0));
    drain(1, 700);
    chk("err_saturated", 32'(err_count), 32'd255);

    // Random legal sweep over all families with random consumer stalls
    for (int i = 0; i < 320; i++) pend.push_back(rnd(1'b1, i % 16));
    drain(2, 2000);

    // Fully random fields, including aliasing combinations
    for (int i = 0; i < 160; i++) pend.push_back(rnd(1'b0, int'($urandom_range(0, 15))));
    drain(2, 1000);

    // Asynchronous reset with two words buffered
    pend.push_back(rnd(1'b1, 3));
    pend.push_back(rnd(1'b1, 13));
    rmode = 0;
    for (int i = 0; i < 3; i++) cycle();
    chk("prerst_out_valid", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_reset_state("midrst");
    sb.delete(); pend.delete();
    m_icnt = '0; m_ecnt = '0;
    @(negedge clk);
    rst = 1'b0;
    got.delete(); gcyc.delete();
    pend.push_back(mk(0, 14, 4, 0, 0, 1, 2, 12'h0FF));
    drain(1, 10);
    chk("postrst_word", got[0], 32'hE28120FF);
    chk("postrst_instr_count", 32'(instr_count), 32'd1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/arm_instr_encoder.md
# arm_instr_encoder

Streaming ARMv4 instruction encoder: accepts a decode-family number plus operand fields over a valid/ready handshake and emits the 32-bit instruction word over a second valid/ready handshake. It is the inverse of the family decoder: every word it produces decodes back to the requested family. It drives instruction-memory preload and the core's directed-test stimulus path, and buffers up to two encoded words.

## Interface
Parameters
- DEPTH, 2, output FIFO entries; only 2 is supported.

Ports
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- in_fnum  in  4  family 0–15, same numbering as the decoder (0 = DP imm … 14 = B/BL, 15 = undefined).
- in_cond  in  4  condition field [31:28].
- in_op  in  4  DP opcode; MUL: op[0]=A; MULL: op[1]=U, op[0]=A; MRS/MSR/SWP: op[0]=R/B.
- in_s  in  1  S bit (DP, MUL, MULL, LDM S).
- in_pubwl  in  5  {P,U,B,W,L} for load/store and LDM; L alone for B/BL (pubwl[0]).
- in_rn, in_rd, in_rs, in_rm  in  4 each  register fields; in_rn is the MSR field mask; MULL RdHi=rd, RdLo=rn.
- in_sh  in  2  shift type; {S,H} for halfword families.
- in_shimm  in  5  shift immediate.
- in_imm  in  24  imm12 = [11:0], reglist = [15:0], branch offset = [23:0].
- out_valid  out  1  word available.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- out_ir  out  32  encoded instruction.
- out_err  out  1  word was built from an illegal field combination.
- instr_count  out  16  words popped, wraps.
- err_count  out  8  erroneous words popped, saturates at 255.

## Operation
- Encoding is combinational from the in_* fields. The result is written into the FIFO on accept.
- Each word is {cond, body}. Bodies by family:
  - f0: 001,op,s,rn,rd,imm12
  - f1: 000,op,s,rn,rd,shimm,sh,0,rm
  - f2: 000,op,s,rn,rd,rs,0,sh,1,rm
  - f3: 000000,A,s,rd,rn,rs,1001,rm
  - f4: 00001,U,A,s,rd,rn,rs,1001,rm
  - f5: 00010,R,00,1111,rd,12'h000
  - f6: 00110,R,10,rn,1111,imm12
  - f7: 00010,R,10,rn,1111,8'h00,rm
  - f8: 010,P,U,B,W,L,rn,rd,imm12
  - f9: 011,P,U,B,W,L,rn,rd,shimm,sh,0,rm
  - f10: 000,P,U,1,W,L,rn,rd,imm[7:4],1,S,H,1,imm[3:0]
  - f11: 000,P,U,0,W,L,rn,rd,0000,1,S,H,1,rm
  - f12: 00010,B,00,rn,rd,0000,1001,rm
  - f13: 100,P,U,s,W,L,rn,imm[15:0]
  - f14: 101,L,imm[23:0]
  - f15: 28'h600_0010
- out_err is set when any of these holds:
  - f0/f1/f2 with op in 8–11 and s=0, because the word would alias MRS/MSR/SWP.
  - f10/f11 with sh=00, because the word would alias SWP/MUL.
  - f13 with reglist=0.
- An erroneous word is still emitted.
- FIFO: 2 entries, with pointer and count registers.
  - in_ready = (count<2) || out_ready.
  - Push and pop in the same cycle leave count unchanged.
  - Accepting when count==2 is legal only with a simultaneous pop.
- out_ir and out_err are driven from the head entry and hold steady while out_valid && !out_ready.
- On each pop, instr_count increments by 1. err_count increments when the popped out_err=1 and err_count<255.

## Timing
- Latency: request accepted at edge N gives out_valid=1 at edge N+1 if the FIFO was empty.
- Throughput: 1 word/cycle sustained when out_ready=1.
- Reset values: out_valid=0, in_ready=1, out_ir=0, out_err=0, instr_count=0, err_count=0, count=0, pointers=0.
- Reset asserted mid-stream discards buffered words immediately, asynchronously; no pop is counted.
- Full FIFO with out_ready=0: in_ready=0. in_* must be held stable by the producer until accepted.
- Empty FIFO: out_ready is ignored, and counters do not change.
- instr_count wraps 0xFFFF→0x0000.

## Structure
- Shared package: family index constants F_DPI..F_UND (0–15), field-position localparams, and the family-name comments.
- One sub-module, `arm_instr_pack`: purely combinational field packing and illegal-combination detection.
- The top level holds the FIFO, handshakes, and counters.

## Test plan
- Reset, then push f0, cond=E, op=4, s=0, rn=1, rd=2, imm=0x0FF, out_ready=1 -> next cycle out_ir=0xE28120FF, out_err=0, instr_count=1.
- Push f14 with L=1, imm=0x00000A, then f8 LDR (pubwl=11001, rn=13, rd=0, imm=4) back-to-back -> 0xEB00000A then 0xE59D0004 on consecutive cycles.
- Hold out_ready=0 and push 3 requests -> two accepted, in_ready=0 on the third. Raise out_ready -> third accepted in the same cycle as the first pop; order preserved.
- f1 with op=10 (CMP), s=0 -> out_err=1, err_count=1. Repeat 300 times -> err_count=255.
- Round-trip: feed every word from a random sweep over all 16 families (legal fields only) into the family decoder -> decoded family number equals in_fnum, out_err=0.
- Assert rst while 2 words are buffered -> out_valid=0 immediately, both counters=0; the next push emerges normally.
